serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised, multi-cycle ripple adder/subtractor.
- Processes DIGIT bits per clock through a chain of DIGIT full-adder cells, with a registered carry between steps.
- Adds start/busy/done handshake, carry-in, subtract mode and signed-overflow detection.
- Arithmetic core for narrow-area datapaths, trading latency for gate count.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per clock; full-adder cells instantiated per step.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- input_a  input  WIDTH  operand A, latched on accepted start.
- input_b  input  WIDTH  operand B, latched on accepted start.
- input_c  input  1  carry-in (add) / borrow-in (sub), latched on accepted start.
- sub  input  1  mode, latched on accepted start: 0 = A+B+c, 1 = A-B-c.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: results valid.
- output_l  output  WIDTH  result sum/difference.
- output_h  output  1  carry-out (add); in sub mode 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst_n=0, async) forces:
  - state IDLE, busy=0, done=0, output_l=0, output_h=0, overflow=0.
  - internal shift registers, step counter and carry all cleared.
  - An in-flight operation is discarded; no done is produced for it.
- States: IDLE, RUN.
- IDLE, start=1 at an edge:
  - latch A; latch B, inverted when sub=1.
  - carry register = input_c when sub=0, ~input_c when sub=1.
  - counter=0; go to RUN; busy=1 from the next cycle.
- RUN, each edge:
  - the DIGIT LSBs of the A/B shift registers plus the carry register pass through the DIGIT-cell chain.
  - sum digit shifts into the result register from the MSB end; carry register takes the chain carry-out.
  - A/B shift right by DIGIT; counter increments.
- Final step (counter = WIDTH/DIGIT-1):
  - output_l <= completed result; output_h <= final carry.
  - overflow <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - done <= 1 for exactly one cycle; busy <= 0; back to IDLE.
- Latency: start accepted at edge 0 -> done high after edge N, where N = WIDTH/DIGIT.
  - busy high for N cycles.
- Back-to-back: start may be high in the same cycle done is high (state is IDLE); it is accepted, giving a throughput of one result per N cycles.
- start while busy=1 is ignored; operands and mode changes during RUN have no effect.
- output_l, output_h and overflow update only at completion and hold until the next completion or reset; they never show partial results.
- WIDTH=DIGIT (N=1) is legal: single-cycle registered adder with done one edge after start.

Test Plan:
- WIDTH=8, DIGIT=1, A=0xFF, B=0x01, c=0, sub=0:
  - done exactly 8 cycles after start.
  - output_l=0x00, output_h=1, overflow=0.
- A=0x7F, B=0x01, c=0, sub=0 -> output_l=0x80, output_h=0, overflow=1.
- Subtract, A=0x05, B=0x07, c=0, sub=1 -> output_l=0xFE, output_h=0 (borrow), overflow=0.
- Subtract, A=0x80, B=0x01, c=0, sub=1 -> output_l=0x7F, output_h=1, overflow=1.
- WIDTH=16, DIGIT=4, A=0x1234, B=0x0FCD, c=1, sub=0:
  - done after 4 cycles; output_l=0x2202, output_h=0.
  - start re-asserted during done cycle: second result after 4 more cycles.
  - start held during busy: no extra operation.
- rst_n pulsed low at cycle 3 of a WIDTH=8 run:
  - all outputs 0 immediately, no done.
  - a fresh start after release completes normally in 8 cycles.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle ripple adder/subtractor.
//
// The adder handles DIGIT bits on every clock edge. It passes them through a chain of DIGIT
// full-adder cells, and a registered carry links one step to the next. A complete WIDTH-bit
// operation takes N = WIDTH/DIGIT edges after start is accepted. This design trades latency
// for a small number of adder cells.
//
// Parameters:
//   WIDTH     operand/result width in bits; must be a multiple of DIGIT
//   DIGIT     bits processed per clock (full-adder cells in the chain)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset; discards any in-flight operation
//   start     request; sampled only while idle (busy=0)
//   input_a   operand A, latched on accepted start
//   input_b   operand B, latched on accepted start
//   input_c   carry-in (add) / borrow-in (sub), latched on accepted start
//   sub       mode, latched on accepted start: 0 = A+B+c, 1 = A-B-c
//   busy      operation in progress
//   done      one-cycle pulse, result outputs valid
//   output_l  sum/difference; updates only on completion
//   output_h  carry-out; in sub mode 1 means no borrow
//   overflow  signed two's-complement overflow of the last completed operation
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             input_c,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] output_l,
  output logic             output_h,
  output logic             overflow
);

  localparam int unsigned NSteps = WIDTH / DIGIT;
  // Keep the counter at least one bit wide so that N=1 stays legal.
  localparam int unsigned CntW   = (NSteps > 1) ? $clog2(NSteps) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NSteps - 1);

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   out_l_q, out_l_d;
  logic               out_h_q, out_h_d;
  logic               ovf_q, ovf_d;

  // Ripple chain: DIGIT full-adder cells fed by the LSBs of the operand shift registers.
  // chain_c[i] is the carry into cell i, so chain_c[0] is the registered carry.
  logic [DIGIT-1:0]   chain_s;
  logic [DIGIT:0]     chain_c;

  always_comb begin
    logic c;
    c          = carry_q;
    chain_c    = '0;
    chain_s    = '0;
    chain_c[0] = carry_q;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      chain_s[i]   = a_q[i] ^ b_q[i] ^ c;
      c            = (a_q[i] & b_q[i]) | (a_q[i] & c) | (b_q[i] & c);
      chain_c[i+1] = c;
    end
  end

  // The new digit enters the result register at the MSB end, and older digits move toward
  // the LSB. After NSteps shifts the digits sit in their proper positions. The concatenate-
  // and-slice form also handles WIDTH == DIGIT without a zero-width slice.
  logic [WIDTH+DIGIT-1:0] res_shift;
  assign res_shift = {chain_s, res_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    out_l_d = out_l_q;
    out_h_d = out_h_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Subtraction is A + ~B + ~borrow, so only B and the carry seed change with mode.
          a_d     = input_a;
          b_d     = sub ? ~input_b : input_b;
          carry_d = sub ? ~input_c : input_c;
          res_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shift[WIDTH+DIGIT-1:DIGIT];
        carry_d = chain_c[DIGIT];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // The top cell of this last step holds bit WIDTH-1. Its carry-in and carry-out
          // give the signed overflow.
          out_l_d = res_shift[WIDTH+DIGIT-1:DIGIT];
          out_h_d = chain_c[DIGIT];
          ovf_d   = chain_c[DIGIT-1] ^ chain_c[DIGIT];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      out_l_q <= '0;
      out_h_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      out_l_q <= out_l_d;
      out_h_q <= out_h_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign done     = done_q;
  assign output_l = out_l_q;
  assign output_h = out_h_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder. Two instances share clock and reset:
//   u_dut8  WIDTH=8,  DIGIT=1 (N=8)
//   u_dut16 WIDTH=16, DIGIT=4 (N=4)
// The bench drives directed vectors and checks them against hand-computed results.
module tb_serial_adder;

  logic clk;
  logic rst_n;

  logic        s8, c8, sub8, busy8, done8, h8, ov8;
  logic [7:0]  a8, b8, l8;
  logic        s16, c16, sub16, busy16, done16, h16, ov16;
  logic [15:0] a16, b16, l16;

  int n_cmp = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (s8),
    .input_a  (a8),
    .input_b  (b8),
    .input_c  (c8),
    .sub      (sub8),
    .busy     (busy8),
    .done     (done8),
    .output_l (l8),
    .output_h (h8),
    .overflow (ov8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (s16),
    .input_a  (a16),
    .input_b  (b16),
    .input_c  (c16),
    .sub      (sub16),
    .busy     (busy16),
    .done     (done16),
    .output_l (l16),
    .output_h (h16),
    .overflow (ov16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation. Entered and left #1 after a rising edge.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic sb, input logic [7:0] exp_l,
                      input logic exp_h, input logic exp_ov);
    int cyc;
    int nbusy;
    a8 = a; b8 = b; c8 = c; sub8 = sb; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    nbusy = busy8 ? 1 : 0;
    cyc = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        cyc = i;
        break;
      end
      if (busy8) nbusy++;
    end
    check({tag, ":latency"}, cyc, 8);
    check({tag, ":busy_cycles"}, nbusy, 8);
    check({tag, ":busy_at_done"}, busy8, 0);
    check({tag, ":output_l"}, l8, exp_l);
    check({tag, ":output_h"}, h8, exp_h);
    check({tag, ":overflow"}, ov8, exp_ov);
    @(posedge clk); #1;
    check({tag, ":done_pulse"}, done8, 0);
    check({tag, ":hold_l"}, l8, exp_l);
  endtask

  // Waits for the 16-bit done after a start accepted at the previous edge.
  task automatic wait16(output int cyc);
    cyc = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done16) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int ndone;
    int first;

    rst_n = 1'b0;
    s8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; sub8 = 1'b0;
    s16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0; sub16 = 1'b0;
    #1;
    check("rst:busy8", busy8, 0);
    check("rst:done8", done8, 0);
    check("rst:l8", l8, 0);
    check("rst:h8", h8, 0);
    check("rst:ov8", ov8, 0);
    check("rst:busy16", busy16, 0);
    check("rst:l16", l16, 0);
    #20;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8-bit add and subtract
    run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run8("add_cin",   8'h40, 8'h3F, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
    run8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    run8("sub_bin",   8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);
    run8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // 16-bit, 4 bits/step, back-to-back start in the done cycle
    a16 = 16'h1234; b16 = 16'h0FCD; c16 = 1'b1; sub16 = 1'b0; s16 = 1'b1;
    @(posedge clk); #1;
    s16 = 1'b0;
    check("w16_busy", busy16, 1);
    wait16(cyc);
    check("w16_a:latency", cyc, 4);
    check("w16_a:output_l", l16, 16'h2202);
    check("w16_a:output_h", h16, 0);
    check("w16_a:overflow", ov16, 0);
    a16 = 16'hFFFF; b16 = 16'h0001; c16 = 1'b0; s16 = 1'b1;
    @(posedge clk); #1;
    s16 = 1'b0;
    check("w16_b2b:busy", busy16, 1);
    wait16(cyc);
    check("w16_b2b:latency", cyc, 4);
    check("w16_b2b:output_l", l16, 16'h0000);
    check("w16_b2b:output_h", h16, 1);

    // start held high while busy, with operands changed mid-run, runs one operation only
    @(posedge clk); #1;
    a16 = 16'h7000; b16 = 16'h1000; c16 = 1'b0; s16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'h0000; b16 = 16'h0000; sub16 = 1'b1;
    ndone = 0;
    first = 99;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 3) s16 = 1'b0;
      if (done16) begin
        ndone++;
        if (first == 99) first = i;
      end
    end
    check("w16_hold:done_count", ndone, 1);
    check("w16_hold:latency", first, 4);
    check("w16_hold:busy_after", busy16, 0);
    check("w16_hold:output_l", l16, 16'h8000);
    check("w16_hold:overflow", ov16, 1);

    // Reset at cycle 3 of an 8-bit run, then a fresh run
    a8 = 8'h55; b8 = 8'h22; c8 = 1'b0; sub8 = 1'b0; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst:busy8", busy8, 0);
    check("arst:done8", done8, 0);
    check("arst:l8", l8, 0);
    check("arst:h8", h8, 0);
    check("arst:ov8", ov8, 0);
    check("arst:l16", l16, 0);
    check("arst:ov16", ov16, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    check("arst:no_done", ndone, 0);
    check("arst:l8_still0", l8, 0);
    run8("post_rst", 8'h55, 8'h22, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
